mem_stage: RTL and testbench

Memory-access stage of the GeMIPS pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered write-back triple and memory op/address/data and runs a request/acknowledge transaction on the data bus for loads and stores. It formats load data (byte/half extraction and sign/zero extension) and raises a stall request while the bus is busy. Outputs feed the MEM/WB register and the ID forwarding path.

---
 rtl/mem_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the GeMIPS pipeline.
// Runs a req/ack data-bus transaction for loads and stores, formats load data
// and stalls the upstream pipeline while the bus is busy.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned-access detection).
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_mem_op,
    input  logic [31:0] mem_mem_addr_i,
    input  logic [31:0] mem_mem_data_i,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        stall_req,
    output logic        ram_req,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        excpt_misalign
);

    // Memory op encodings shared with the decode stage
    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h01;
    localparam logic [7:0] MEM_LBU = 8'h02;
    localparam logic [7:0] MEM_LH  = 8'h03;
    localparam logic [7:0] MEM_LHU = 8'h04;
    localparam logic [7:0] MEM_LW  = 8'h05;
    localparam logic [7:0] MEM_SB  = 8'h06;
    localparam logic [7:0] MEM_SH  = 8'h07;
    localparam logic [7:0] MEM_SW  = 8'h08;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_rdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_signed;
    logic [1:0]  w_size;
    logic [1:0]  w_a;
    logic        w_misalign;
    logic        w_req;

    logic [3:0]  w_be_byte;
    logic [31:0] w_wdata_byte;
    logic [31:0] w_wdata_half;
    logic [7:0]  w_rbyte [4];

    logic [3:0]  w_be;
    logic [31:0] w_store_data;
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_load_data;

    assign w_a = mem_mem_addr_i[1:0];

    // Decode the memory op into direction, access size and signedness
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = SZ_WORD;
        case (mem_mem_op)
            MEM_LB:  begin w_is_load  = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
            MEM_LBU: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
            MEM_LH:  begin w_is_load  = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
            MEM_LHU: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
            MEM_LW:  begin w_is_load  = 1'b1; w_size = SZ_WORD; end
            MEM_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            MEM_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF; end
            MEM_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD; end
            MEM_NOP: begin end
            default: begin end
        endcase
    end

    assign w_is_mem = w_is_load | w_is_store;

`ifdef MEM_ALIGN_CHECK_EN
    // Halves must sit on even addresses, words on multiples of four
    assign w_misalign = w_is_mem &&
                        (((w_size == SZ_HALF) && w_a[0]) ||
                         ((w_size == SZ_WORD) && (w_a != 2'b00)));
`else
    // Without the check, low address bits below the access size are dropped
    assign w_misalign = 1'b0;
`endif

    // Per-lane byte enables, store replication and read-word byte split
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_be_byte[gi]              = (w_a == 2'(gi));
            assign w_wdata_byte[gi*8 +: 8]    = mem_mem_data_i[7:0];
            assign w_wdata_half[gi*8 +: 8]    = mem_mem_data_i[(gi % 2)*8 +: 8];
            assign w_rbyte[gi]                = r_rdata[gi*8 +: 8];
        end
    endgenerate

    // Select byte enables and bus write data for the access size
    always_comb begin
        w_be         = 4'b1111;
        w_store_data = mem_mem_data_i;
        case (w_size)
            SZ_BYTE: begin
                w_be         = w_be_byte;
                w_store_data = w_wdata_byte;
            end
            SZ_HALF: begin
                w_be         = w_a[1] ? 4'b1100 : 4'b0011;
                w_store_data = w_wdata_half;
            end
            default: begin
                w_be         = 4'b1111;
                w_store_data = mem_mem_data_i;
            end
        endcase
    end

    // Extract and extend the addressed byte/half from the captured read word
    always_comb begin
        w_sel_byte  = w_rbyte[w_a];
        w_sel_half  = w_a[1] ? r_rdata[31:16] : r_rdata[15:0];
        w_load_data = r_rdata;
        case (w_size)
            SZ_BYTE: w_load_data = w_signed ? {{24{w_sel_byte[7]}}, w_sel_byte}
                                            : {24'd0, w_sel_byte};
            SZ_HALF: w_load_data = w_signed ? {{16{w_sel_half[15]}}, w_sel_half}
                                            : {16'd0, w_sel_half};
            default: w_load_data = r_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic: request from IDLE, hold in WAIT until ack,
    // DONE lasts exactly one cycle while the pipeline advances
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem && !w_misalign) begin
                    w_state_next = ram_ack ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_is_mem || w_misalign) begin
                    w_state_next = ST_IDLE;
                end else if (ram_ack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the read word on the acknowledged bus cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_req && ram_ack) begin
            r_rdata <= ram_rdata;
        end
    end

    // FSM outputs: write-back mux, stall, bus request and misalign flag
    always_comb begin
        wb_we          = mem_we;
        wb_waddr       = mem_waddr;
        wb_wdata       = mem_wdata;
        stall_req      = 1'b0;
        w_req          = 1'b0;
        excpt_misalign = 1'b0;
        if (rst) begin
            wb_we    = 1'b0;
            wb_waddr = 5'd0;
            wb_wdata = 32'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    if (w_is_mem) begin
                        wb_we = 1'b0;
                        if (w_misalign) begin
                            excpt_misalign = 1'b1;
                        end else begin
                            w_req     = 1'b1;
                            stall_req = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_is_load) begin
                        wb_wdata = w_load_data;
                    end
                end
                default: begin end
            endcase
        end
    end

    // Bus fields are driven only while requesting and are otherwise zero
    always_comb begin
        ram_req   = w_req;
        ram_we    = w_req & w_is_store;
        ram_be    = w_req ? w_be : 4'd0;
        ram_addr  = w_req ? {mem_mem_addr_i[31:2], 2'b00} : 32'd0;
        ram_wdata = w_req ? w_store_data : 32'd0;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed-vector scoreboard bench for mem_stage.
// Stimulus pushes expected write-back and bus fields; monitors compare them.
module tb_mem_stage;

    localparam logic [7:0] MEM_NOP = 8'h00;
    localparam logic [7:0] MEM_LB  = 8'h01;
    localparam logic [7:0] MEM_LBU = 8'h02;
    localparam logic [7:0] MEM_LH  = 8'h03;
    localparam logic [7:0] MEM_LHU = 8'h04;
    localparam logic [7:0] MEM_LW  = 8'h05;
    localparam logic [7:0] MEM_SB  = 8'h06;
    localparam logic [7:0] MEM_SH  = 8'h07;
    localparam logic [7:0] MEM_SW  = 8'h08;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_mem_op;
    logic [31:0] mem_mem_addr_i;
    logic [31:0] mem_mem_data_i;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        stall_req;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        excpt_misalign;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        excpt;
        logic [7:0]  stalls;
    } wb_exp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       checks = 0;
    int       errors = 0;
    logic     tb_done = 1'b0;
    logic [7:0] stall_cnt = 8'd0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .mem_mem_op     (mem_mem_op),
        .mem_mem_addr_i (mem_mem_addr_i),
        .mem_mem_data_i (mem_mem_data_i),
        .wb_we          (wb_we),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata),
        .stall_req      (stall_req),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_be         (ram_be),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .ram_ack        (ram_ack),
        .excpt_misalign (excpt_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus monitor: request fields must match the expected access every cycle
    always @(negedge clk) begin
        if (!rst && !tb_done && ram_req) begin
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got we=%0b be=%b addr=%h wdata=%h, required no request",
                         ram_we, ram_be, ram_addr, ram_wdata);
            end else begin
                if ({ram_we, ram_be, ram_addr, ram_wdata} !== bus_q[0]) begin
                    errors++;
                    $display("FAIL bus_fields: got we=%0b be=%b addr=%h wdata=%h, required we=%0b be=%b addr=%h wdata=%h",
                             ram_we, ram_be, ram_addr, ram_wdata,
                             bus_q[0].we, bus_q[0].be, bus_q[0].addr, bus_q[0].wdata);
                end else begin
                    $display("bus  we=%0b be=%b addr=%h wdata=%h ack=%0b ok",
                             ram_we, ram_be, ram_addr, ram_wdata, ram_ack);
                end
                if (ram_ack) void'(bus_q.pop_front());
            end
        end
    end

    // Write-back monitor: each non-stalled cycle retires one expected result
    always @(negedge clk) begin
        wb_exp_t e;
        if (rst) begin
            stall_cnt = 8'd0;
        end else if (!tb_done) begin
            if (stall_req) begin
                stall_cnt = stall_cnt + 8'd1;
                if (stall_cnt == 8'd40) begin
                    checks++;
                    errors++;
                    $display("FAIL stall_timeout: got %0d stall cycles, required at most 39", stall_cnt);
                end
            end else begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: got we=%0b waddr=%0d wdata=%h, required no result",
                             wb_we, wb_waddr, wb_wdata);
                end else begin
                    e = wb_q.pop_front();
                    if ({wb_we, wb_waddr, wb_wdata, excpt_misalign, stall_cnt, ram_req} !== {e, 1'b0}) begin
                        errors++;
                        $display("FAIL wb_result: got we=%0b waddr=%0d wdata=%h exc=%0b stalls=%0d req=%0b, required we=%0b waddr=%0d wdata=%h exc=%0b stalls=%0d req=0",
                                 wb_we, wb_waddr, wb_wdata, excpt_misalign, stall_cnt, ram_req,
                                 e.we, e.waddr, e.wdata, e.excpt, e.stalls);
                    end else begin
                        $display("wb   we=%0b waddr=%0d wdata=%h exc=%0b stalls=%0d ok",
                                 wb_we, wb_waddr, wb_wdata, excpt_misalign, stall_cnt);
                    end
                end
                stall_cnt = 8'd0;
            end
        end
    end

    // Issue one op: queue expectations, then play the ack after nwait cycles
    task automatic do_op(input logic [7:0] op, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic [31:0] addr,
                         input logic [31:0] data, input int nwait, input logic [31:0] rdata,
                         input logic misal, input logic [3:0] be, input logic rwe,
                         input logic [31:0] rwdata, input logic exp_we,
                         input logic [31:0] exp_wdata);
        wb_exp_t  e;
        bus_exp_t b;
        logic     is_mem;
        is_mem         = (op != MEM_NOP);
        mem_mem_op     = op;
        mem_we         = we;
        mem_waddr      = waddr;
        mem_wdata      = wdata;
        mem_mem_addr_i = addr;
        mem_mem_data_i = data;
        e.we     = exp_we;
        e.waddr  = waddr;
        e.wdata  = exp_wdata;
        e.excpt  = misal;
        e.stalls = (is_mem && !misal) ? 8'(nwait + 1) : 8'd0;
        wb_q.push_back(e);
        if (is_mem && !misal) begin
            b.we    = rwe;
            b.be    = be;
            b.addr  = {addr[31:2], 2'b00};
            b.wdata = rwdata;
            bus_q.push_back(b);
            for (int i = 0; i <= nwait; i++) begin
                ram_ack   = (i == nwait);
                ram_rdata = (i == nwait) ? rdata : 32'h5A5A5A5A;
                @(posedge clk); #1;
            end
            ram_ack   = 1'b0;
            ram_rdata = 32'hA5A5A5A5;
        end
        @(posedge clk); #1;
    endtask

    // All outputs must read zero while rst is asserted
    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        checks++;
        if ({wb_we, wb_waddr, wb_wdata, stall_req, ram_req, ram_we, ram_be,
             ram_addr, ram_wdata, excpt_misalign} !== '0) begin
            errors++;
            $display("FAIL %s: got wb_we=%0b wb_waddr=%0d wb_wdata=%h stall=%0b req=%0b we=%0b be=%b addr=%h wdata=%h exc=%0b, required all 0",
                     tag, wb_we, wb_waddr, wb_wdata, stall_req, ram_req, ram_we, ram_be,
                     ram_addr, ram_wdata, excpt_misalign);
        end else begin
            $display("rst  %s outputs all zero ok", tag);
        end
    endtask

    initial begin
        // Reset with a live load on the inputs: outputs still forced to 0
        rst            = 1'b1;
        ram_ack        = 1'b1;
        ram_rdata      = 32'hFFFFFFFF;
        mem_we         = 1'b1;
        mem_waddr      = 5'd31;
        mem_wdata      = 32'hFFFFFFFF;
        mem_mem_op     = MEM_LW;
        mem_mem_addr_i = 32'h00000104;
        mem_mem_data_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        check_reset_outputs("reset_start");
        @(posedge clk); #1;
        rst     = 1'b0;
        ram_ack = 1'b0;

        //     op       we    wa     wdata          addr           data           nw rdata          mis   be       rwe   rwdata         ewe   ewdata
        do_op(MEM_NOP, 1'b1, 5'd5, 32'h00001234, 32'h00000000, 32'h00000000, 0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'h00001234);
        do_op(MEM_LB,  1'b1, 5'd3, 32'h00000055, 32'h00000103, 32'h11223344, 0, 32'h80AABBCC, 1'b0, 4'b1000, 1'b0, 32'h44444444, 1'b1, 32'hFFFFFF80);
        do_op(MEM_LBU, 1'b1, 5'd4, 32'h00000055, 32'h00000103, 32'h11223344, 0, 32'h80AABBCC, 1'b0, 4'b1000, 1'b0, 32'h44444444, 1'b1, 32'h00000080);
        do_op(MEM_SH,  1'b0, 5'd7, 32'h0000CAFE, 32'h00000202, 32'h0000BEEF, 3, 32'h0,         1'b0, 4'b1100, 1'b1, 32'hBEEFBEEF, 1'b0, 32'h0000CAFE);
        do_op(MEM_LHU, 1'b1, 5'd8, 32'h00000000, 32'h00000010, 32'h00000000, 0, 32'h1234ABCD, 1'b0, 4'b0011, 1'b0, 32'h00000000, 1'b1, 32'h0000ABCD);
        do_op(MEM_LW,  1'b1, 5'd9, 32'h00000000, 32'h00000014, 32'h00000000, 1, 32'hDEADBEEF, 1'b0, 4'b1111, 1'b0, 32'h00000000, 1'b1, 32'hDEADBEEF);
        do_op(MEM_LH,  1'b1, 5'd10,32'h00000000, 32'h00000012, 32'h00000000, 0, 32'h80010000, 1'b0, 4'b1100, 1'b0, 32'h00000000, 1'b1, 32'hFFFF8001);
        do_op(MEM_LB,  1'b1, 5'd11,32'h00000000, 32'h00000101, 32'h00000000, 2, 32'h80AA7FCC, 1'b0, 4'b0010, 1'b0, 32'h00000000, 1'b1, 32'h0000007F);
        do_op(MEM_SB,  1'b0, 5'd12,32'h00000077, 32'h00000042, 32'h000000A5, 0, 32'h0,         1'b0, 4'b0100, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h00000077);
        do_op(MEM_SW,  1'b0, 5'd13,32'h00000088, 32'h00000040, 32'h12345678, 2, 32'h0,         1'b0, 4'b1111, 1'b1, 32'h12345678, 1'b0, 32'h00000088);
        do_op(MEM_LW,  1'b0, 5'd0, 32'h00000000, 32'h00000020, 32'h00000000, 0, 32'hFFFFFFFF, 1'b0, 4'b1111, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFFFF);
`ifdef MEM_ALIGN_CHECK_EN
        do_op(MEM_LW,  1'b1, 5'd0, 32'h00000000, 32'h00000006, 32'h00000000, 0, 32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         1'b0, 32'h00000000);
        do_op(MEM_SH,  1'b0, 5'd0, 32'h00000000, 32'h00000201, 32'h00001357, 0, 32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         1'b0, 32'h00000000);
`else
        do_op(MEM_LW,  1'b1, 5'd14,32'h00000000, 32'h00000006, 32'h00000000, 0, 32'h0BADF00D, 1'b0, 4'b1111, 1'b0, 32'h00000000, 1'b1, 32'h0BADF00D);
        do_op(MEM_SH,  1'b0, 5'd15,32'h00000099, 32'h00000201, 32'h00001357, 1, 32'h0,         1'b0, 4'b0011, 1'b1, 32'h13571357, 1'b0, 32'h00000099);
`endif

        // Reset while the bus is in WAIT: access abandoned, back to IDLE
        begin
            bus_exp_t b;
            mem_mem_op     = MEM_LW;
            mem_we         = 1'b1;
            mem_waddr      = 5'd2;
            mem_wdata      = 32'h0;
            mem_mem_addr_i = 32'h00000020;
            mem_mem_data_i = 32'h0;
            ram_ack        = 1'b0;
            b.we    = 1'b0;
            b.be    = 4'b1111;
            b.addr  = 32'h00000020;
            b.wdata = 32'h0;
            bus_q.push_back(b);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b1;
            check_reset_outputs("reset_mid_wait");
            @(posedge clk); #1;
            rst = 1'b0;
            bus_q.delete();
        end
        do_op(MEM_NOP, 1'b0, 5'd0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b0, 32'h00000000);
        do_op(MEM_LBU, 1'b1, 5'd6, 32'h00000000, 32'h00000102, 32'h00000000, 0, 32'h00C30000, 1'b0, 4'b0100, 1'b0, 32'h00000000, 1'b1, 32'h000000C3);
        do_op(MEM_NOP, 1'b1, 5'd17,32'hCAFEF00D, 32'h00000000, 32'h00000000, 0, 32'h0,         1'b0, 4'b0000, 1'b0, 32'h0,         1'b1, 32'hCAFEF00D);

        tb_done = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_q.size() != 0 || bus_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d wb and %0d bus entries pending, required 0 and 0",
                     wb_q.size(), bus_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
